// File: rtl/spi_frame_tx.sv
// spi_frame_tx: serialises a latched count word over SPI, MSB first,
// paced by falling edges of the divided clock sclk (sampled in clk).
// Ports: clk, rst_n (async, active-low), sclk (divided clock),
//   start/data (request + payload), spi_sck/mosi/cs_n (SPI master),
//   busy (frame in flight), done (one-clk end-of-frame pulse).
// Option: define SPI_PARITY_EN to append an even-parity bit.
module spi_frame_tx #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              spi_sck,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done
);

`ifdef SPI_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam logic [5:0] LAST = 6'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic             sclk_q;
  logic             fall;
  logic [NBITS-1:0] load;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic             sck_q, sck_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign fall = sclk_q & ~sclk;

`ifdef SPI_PARITY_EN
  assign load = {data, ^data};
`else
  assign load = data;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    sck_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = load;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ALIGN;
        end
      end
      // The accepting clk is spent in IDLE, so a fall
      // on that same clk can never open the frame.
      ALIGN: begin
        if (fall) begin
          cs_n_d  = 1'b0;
          mosi_d  = shift_q[NBITS-1];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sck_d = sclk;
        if (fall) begin
          if (cnt_q == LAST) begin
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            sck_d   = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            shift_d = {shift_q[NBITS-2:0], 1'b0};
            mosi_d  = shift_q[NBITS-2];
            cnt_d   = cnt_q + 6'd1;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sclk_q  <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      sck_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      sck_q   <= sck_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign spi_sck = sck_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_spi_frame_tx.sv
// tb_spi_frame_tx: directed frames through spi_frame_tx with a
// slave-side capture monitor checked against an expectation queue.
module tb_spi_frame_tx;

`ifdef SPI_PARITY_EN
  localparam int NB = 33;
`else
  localparam int NB = 32;
`endif

  typedef struct {
    logic [63:0] frame;
    int          nbits;
    int          low;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        start = 1'b0;
  logic [31:0] data = '0;
  logic        spi_sck, mosi, cs_n, busy, done;

  int   n_cmp = 0;
  int   n_err = 0;
  int   hp = 4;
  int   sc = 0;
  logic fell = 1'b0;
  exp_t exp_q[$];

  logic [63:0] cap = '0;
  int   mon_nb = 0;
  int   mon_low = 0;
  int   done_cnt = 0;
  int   sck_bad = 0;
  logic sck_prev = 1'b0;
  logic cs_prev = 1'b1;

  spi_frame_tx #(.DATA_W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sclk    (sclk),
    .start   (start),
    .data    (data),
    .spi_sck (spi_sck),
    .mosi    (mosi),
    .cs_n    (cs_n),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Divided clock: toggles every hp clk cycles.
  initial forever begin
    @(posedge clk);
    #1;
    fell = 1'b0;
    if (sc >= hp - 1) begin
      sc   = 0;
      fell = sclk;
      sclk = ~sclk;
    end else begin
      sc++;
    end
  end

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] exp_frame(
    input logic [31:0] d);
`ifdef SPI_PARITY_EN
    return {31'b0, d, ^d};
`else
    return {32'b0, d};
`endif
  endfunction

  // Slave model: capture mosi on spi_sck rise while cs_n low.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cap     = '0;
      mon_nb  = 0;
      mon_low = 0;
    end else begin
      if (cs_n && spi_sck) sck_bad++;
      if (done) done_cnt++;
      if (!cs_n) begin
        mon_low++;
        if (spi_sck && !sck_prev) begin
          cap = {cap[62:0], mosi};
          mon_nb++;
        end
      end
      if (cs_n && !cs_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("frame_data", cap, e.frame);
          check("frame_bits", 64'(mon_nb), 64'(e.nbits));
          check("cs_low_clks", 64'(mon_low), 64'(e.low));
        end
        cap     = '0;
        mon_nb  = 0;
        mon_low = 0;
      end
    end
    sck_prev = spi_sck;
    cs_prev  = cs_n;
  end

  task automatic send(input logic [31:0] d,
                      input bit accepted);
    exp_t e;
    start = 1'b1;
    data  = d;
    if (accepted) begin
      e.frame = exp_frame(d);
      e.nbits = NB;
      e.low   = NB * 2 * hp;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound,
                           output bit busy_drop);
    int n;
    n = 0;
    busy_drop = 1'b0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (!busy) busy_drop = 1'b1;
      n++;
      if (n > bound) begin
        check("done_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic frame(input logic [31:0] d,
                       input int bound);
    int  d0;
    bit  bd;
    d0 = done_cnt;
    send(d, 1'b1);
    wait_done(bound, bd);
    repeat (3) @(posedge clk);
    #2;
    check("done_once", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int  d0;
    int  n;
    bit  bd;
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    check("rst_cs_n", 64'(cs_n), 64'd1);
    check("rst_sck", 64'(spi_sck), 64'd0);
    check("rst_mosi", 64'(mosi), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;

    // Second start 3 clk later must be ignored.
    d0 = done_cnt;
    send(32'hA5A5_0F0F, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    send(32'hFFFF_FFFF, 1'b0);
    wait_done(2000, bd);
    check("busy_held", 64'(bd), 64'd0);
    repeat (3) @(posedge clk);
    #2;
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("busy_idle", 64'(busy), 64'd0);

    // Abort mid-frame at bit 10.
    send(32'hDEAD_BEEF, 1'b0);
    n = 0;
    while (mon_nb < 10 && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("bit10_reached", 64'(mon_nb >= 10), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_cs_n", 64'(cs_n), 64'd1);
    check("abort_sck", 64'(spi_sck), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    frame(32'h0000_0001, 2000);

    // Start coincident with an sclk fall.
    n = 0;
    while (!fell && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    d0 = done_cnt;
    send(32'hC3C3_3C3C, 1'b1);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (!cs_n) break;
    end
    check("fall_latency", 64'(n), 64'(2 * hp + 1));
    wait_done(2000, bd);
    repeat (3) @(posedge clk);
    #2;
    check("done_once", 64'(done_cnt - d0), 64'd1);

    frame(32'h0000_0007, 2000);
    frame(32'h0000_0003, 2000);

    hp = 101;
    repeat (300) @(posedge clk);
    #2;
    frame(32'h1234_5678, 20000);

    repeat (10) @(posedge clk);
    #2;
    check("sck_outside_cs", 64'(sck_bad), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
